// File: rtl/hpu_col_streamer.sv
// hpu_col_streamer: per-command column walker feeding the HPU pivot search.
// Streams every row not yet marked as pivoted, in ascending order, through a
// 2-entry skid FIFO fed by a column buffer with 1-cycle read latency.
module hpu_col_streamer #(
   parameter int DATA_W    = 32,
   parameter int ROW_IDX_W = 8,
   parameter int MAX_ROWS  = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_start,
   input  logic [ROW_IDX_W:0]   cmd_len,
   input  logic                 cmd_clear,
   output logic                 busy,
   output logic                 done,
   output logic                 empty,
   input  logic                 mark_valid,
   output logic                 mark_ready,
   input  logic [ROW_IDX_W-1:0] mark_row,
   output logic                 mem_rd_en,
   output logic [ROW_IDX_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0]    mem_rd_data,
   output logic                 piv_start,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_value,
   output logic [ROW_IDX_W-1:0] out_row,
   output logic                 out_last
);

   localparam int LEN_W = ROW_IDX_W + 1;
   // Bitmap spans the full index space so any mark_row indexes safely;
   // rows at or above MAX_ROWS are simply never written.
   localparam int BM_W  = 2 ** ROW_IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_START, S_SCAN, S_DRAIN, S_FIN} state_t;

   state_t                 state;
   logic [BM_W-1:0]        bitmap;
   logic [LEN_W-1:0]       used_cnt;
   logic [LEN_W-1:0]       n_lat;
   logic [LEN_W-1:0]       avail;
   logic [LEN_W-1:0]       rd_cnt;
   logic [ROW_IDX_W-1:0]   scan_ptr;

   // Read in flight (data arrives on mem_rd_data this cycle)
   logic                   infl_v;
   logic [ROW_IDX_W-1:0]   infl_row;
   logic                   infl_last;

   // Skid FIFO, entry 0 is the head
   logic [1:0]             f_cnt;
   logic [DATA_W-1:0]      f0_val, f1_val;
   logic [ROW_IDX_W-1:0]   f0_row, f1_row;
   logic                   f0_last, f1_last;

   logic [1:0]             f_cnt_n;
   logic [1:0]             cnt_tmp;
   logic [DATA_W-1:0]      n0_val, n1_val;
   logic [ROW_IDX_W-1:0]   n0_row, n1_row;
   logic                   n0_last, n1_last;

   logic                   mark_new;
   logic [LEN_W-1:0]       used_eff;
   logic [LEN_W-1:0]       avail_calc;
   logic                   room, rd_fire, advance, scan_last;
   logic                   pop, pop_f, push;

   assign mark_ready = !busy;

   // Mark/clear/start ordering: clear first, then the mark, then avail
   always_comb begin
      mark_new   = mark_valid && !busy && (32'(mark_row) < MAX_ROWS) &&
                   (cmd_clear || !bitmap[mark_row]);
      used_eff   = (cmd_clear ? '0 : used_cnt) + LEN_W'(mark_new);
      avail_calc = (cmd_len > used_eff) ? (cmd_len - used_eff) : '0;
   end

   // Scan issue: skip used rows, read unused rows only when the FIFO has room
   always_comb begin
      room        = (f_cnt == 2'd0) || ((f_cnt == 2'd1) && !infl_v);
      rd_fire     = (state == S_SCAN) && !bitmap[scan_ptr] && room;
      advance     = (state == S_SCAN) && (bitmap[scan_ptr] || room);
      scan_last   = ({1'b0, scan_ptr} == (n_lat - LEN_W'(1)));
      mem_rd_en   = rd_fire;
      mem_rd_addr = rd_fire ? scan_ptr : '0;
   end

   // Output head: FIFO entry 0, or the in-flight read bypassed when empty
   always_comb begin
      out_valid = (f_cnt != 2'd0) || infl_v;
      if (f_cnt != 2'd0) begin
         out_value = f0_val;
         out_row   = f0_row;
         out_last  = f0_last;
      end else if (infl_v) begin
         out_value = mem_rd_data;
         out_row   = infl_row;
         out_last  = infl_last;
      end else begin
         out_value = '0;
         out_row   = '0;
         out_last  = 1'b0;
      end
   end

   // FIFO next state: pop shifts the head out, the arriving read is stored
   // unless it was handed straight through the bypass
   always_comb begin
      pop     = out_valid && out_ready;
      pop_f   = pop && (f_cnt != 2'd0);
      push    = infl_v && !(pop && (f_cnt == 2'd0));
      n0_val  = f0_val;  n0_row = f0_row;  n0_last = f0_last;
      n1_val  = f1_val;  n1_row = f1_row;  n1_last = f1_last;
      if (pop_f) begin
         n0_val  = f1_val;
         n0_row  = f1_row;
         n0_last = f1_last;
      end
      cnt_tmp = f_cnt - {1'b0, pop_f};
      if (push) begin
         if (cnt_tmp == 2'd0) begin
            n0_val  = mem_rd_data;
            n0_row  = infl_row;
            n0_last = infl_last;
         end else begin
            n1_val  = mem_rd_data;
            n1_row  = infl_row;
            n1_last = infl_last;
         end
      end
      f_cnt_n = cnt_tmp + {1'b0, push};
   end

   // Control FSM, bitmap, in-flight tracking and FIFO storage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bitmap    <= '0;
         used_cnt  <= '0;
         n_lat     <= '0;
         avail     <= '0;
         rd_cnt    <= '0;
         scan_ptr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         empty     <= 1'b0;
         piv_start <= 1'b0;
         infl_v    <= 1'b0;
         infl_row  <= '0;
         infl_last <= 1'b0;
         f_cnt     <= '0;
         f0_val    <= '0;  f0_row <= '0;  f0_last <= 1'b0;
         f1_val    <= '0;  f1_row <= '0;  f1_last <= 1'b0;
      end else begin
         piv_start <= 1'b0;
         done      <= 1'b0;
         infl_v    <= rd_fire;
         infl_row  <= scan_ptr;
         infl_last <= (rd_cnt == (avail - LEN_W'(1)));
         if (rd_fire) rd_cnt <= rd_cnt + LEN_W'(1);
         f_cnt  <= f_cnt_n;
         f0_val <= n0_val;  f0_row <= n0_row;  f0_last <= n0_last;
         f1_val <= n1_val;  f1_row <= n1_row;  f1_last <= n1_last;

         case (state)
            S_IDLE: begin
               if (cmd_clear) bitmap <= '0;
               if (mark_new) bitmap[mark_row] <= 1'b1;
               used_cnt <= used_eff;
               if (cmd_start) begin
                  n_lat     <= cmd_len;
                  avail     <= avail_calc;
                  busy      <= 1'b1;
                  piv_start <= (avail_calc != '0);
                  state     <= S_START;
               end
            end
            S_START: begin
               scan_ptr <= '0;
               rd_cnt   <= '0;
               if (avail == '0) begin
                  done  <= 1'b1;
                  empty <= 1'b1;
                  state <= S_FIN;
               end else begin
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (advance) begin
                  if (scan_last) state <= S_DRAIN;
                  else scan_ptr <= scan_ptr + ROW_IDX_W'(1);
               end
            end
            S_DRAIN: begin
               if ((f_cnt == 2'd0) && !infl_v) begin
                  done  <= 1'b1;
                  empty <= 1'b0;
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               empty <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hpu_col_streamer.sv
// Directed self-checking bench for hpu_col_streamer.
module tb_hpu_col_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_start, cmd_clear;
   logic [8:0]  cmd_len;
   logic        busy, done, empty;
   logic        mark_valid, mark_ready;
   logic [7:0]  mark_row;
   logic        mem_rd_en;
   logic [7:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        piv_start;
   logic        out_valid, out_ready;
   logic [31:0] out_value;
   logic [7:0]  out_row;
   logic        out_last;

   hpu_col_streamer #(.DATA_W(32), .ROW_IDX_W(8), .MAX_ROWS(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_clear(cmd_clear),
      .busy(busy), .done(done), .empty(empty),
      .mark_valid(mark_valid), .mark_ready(mark_ready), .mark_row(mark_row),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .piv_start(piv_start),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_row(out_row), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Column buffer: mem[r] = 3r+1, one-cycle read latency
   logic [31:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = 32'(3 * i + 1);
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] v;
      logic [7:0]  r;
      logic        l;
      int          rel;
   } out_t;

   out_t        outs[$];
   int          rd_q[$];
   int          tstart, piv_cnt, piv_rel, first_rd_rel, done_n, done_rel;
   int          rd_n, dl_n;
   logic        done_empty, stall_prev;
   logic [31:0] pv;
   logic [7:0]  pr;
   logic        pl;
   bit          mon_en = 0;

   // Monitor: samples 2 time units after the falling edge
   always @(negedge clk) begin
      int rel;
      #2;
      if (mon_en) begin
         rel = cyc - tstart;
         if (piv_start) begin piv_cnt++; piv_rel = rel; end
         if (mem_rd_en) begin
            chk("outstanding", 64'((rd_n - dl_n) <= 2), 64'd1);
            if (rd_n == 0) first_rd_rel = rel;
            rd_q.push_back(int'(mem_rd_addr));
            rd_n++;
         end
         if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_value", 64'(out_value), 64'(pv));
            chk("hold_row",   64'(out_row),   64'(pr));
            chk("hold_last",  64'(out_last),  64'(pl));
         end
         if (out_valid && out_ready) begin
            outs.push_back('{out_value, out_row, out_last, rel});
            dl_n++;
         end
         stall_prev = out_valid && !out_ready;
         pv = out_value; pr = out_row; pl = out_last;
         if (done) begin done_n++; done_rel = rel; done_empty = empty; end
      end
   end

   task automatic mark(input logic [7:0] r);
      @(negedge clk);
      mark_valid = 1'b1;
      mark_row   = r;
      @(negedge clk);
      mark_valid = 1'b0;
   endtask

   // Issue one command; optional out_ready toggling, busy-time poke, reset
   task automatic run_cmd(input int n, input bit toggle, input bit clr,
                          input int poke_at, input int rst_at);
      logic [3:0] pat;
      pat = 4'b1001;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (k == 0) begin
            outs.delete(); rd_q.delete();
            piv_cnt = 0; piv_rel = -1; first_rd_rel = -1;
            done_n = 0; done_rel = -1; done_empty = 1'b0;
            rd_n = 0; dl_n = 0; stall_prev = 1'b0;
            tstart = cyc; mon_en = 1;
            cmd_start = 1'b1; cmd_len = 9'(n); cmd_clear = clr;
         end else begin
            cmd_start = 1'b0; cmd_clear = 1'b0; mark_valid = 1'b0;
         end
         if (k == poke_at) begin
            cmd_start = 1'b1; cmd_len = 9'd2; cmd_clear = 1'b1;
            mark_valid = 1'b1; mark_row = 8'd6;
            chk("mark_ready_busy", 64'(mark_ready), 64'd0);
         end
         out_ready = toggle ? pat[k % 4] : 1'b1;
         if (rst_at >= 0 && k == rst_at) rst_n = 1'b0;
         if (rst_at >= 0 && k == rst_at + 1) begin
            rst_n = 1'b1;
            #2;
            chk("rst_busy",      64'(busy),        64'd0);
            chk("rst_done",      64'(done),        64'd0);
            chk("rst_empty",     64'(empty),       64'd0);
            chk("rst_piv",       64'(piv_start),   64'd0);
            chk("rst_rd_en",     64'(mem_rd_en),   64'd0);
            chk("rst_rd_addr",   64'(mem_rd_addr), 64'd0);
            chk("rst_out_valid", 64'(out_valid),   64'd0);
            chk("rst_out_value", 64'(out_value),   64'd0);
            chk("rst_out_row",   64'(out_row),     64'd0);
            chk("rst_out_last",  64'(out_last),    64'd0);
            chk("rst_mark_rdy",  64'(mark_ready),  64'd1);
            return;
         end
         if (done_n > 0) return;
         if (k == 299) chk("timeout", 64'd0, 64'd1);
      end
   endtask

   task automatic verify(input string nm, input int rows[$]);
      chk({nm, "_count"}, 64'(outs.size()), 64'(rows.size()));
      chk({nm, "_reads"}, 64'(rd_q.size()), 64'(rows.size()));
      for (int i = 0; i < rows.size(); i++) begin
         if (i < outs.size()) begin
            chk({nm, "_row"},   64'(outs[i].r), 64'(rows[i]));
            chk({nm, "_value"}, 64'(outs[i].v), 64'(3 * rows[i] + 1));
            chk({nm, "_last"},  64'(outs[i].l), 64'(i == rows.size() - 1));
         end
         if (i < rd_q.size()) chk({nm, "_addr"}, 64'(rd_q[i]), 64'(rows[i]));
      end
      chk({nm, "_piv"},   64'(piv_cnt),    64'd1);
      chk({nm, "_done"},  64'(done_n),     64'd1);
      chk({nm, "_empty"}, 64'(done_empty), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; cmd_start = 1'b0; cmd_clear = 1'b0; cmd_len = '0;
      mark_valid = 1'b0; mark_row = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      chk("reset_busy",      64'(busy),       64'd0);
      chk("reset_done",      64'(done),       64'd0);
      chk("reset_out_valid", 64'(out_valid),  64'd0);
      chk("reset_piv",       64'(piv_start),  64'd0);
      chk("reset_rd_en",     64'(mem_rd_en),  64'd0);
      chk("reset_mark_rdy",  64'(mark_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Empty bitmap, N=4, full throughput
      run_cmd(4, 0, 0, -1, -1);
      verify("t1", '{0, 1, 2, 3});
      chk("t1_piv_rel",  64'(piv_rel),      64'd1);
      chk("t1_rd_rel",   64'(first_rd_rel), 64'd2);
      chk("t1_done_rel", 64'(done_rel),     64'd8);
      for (int i = 0; i < outs.size(); i++) chk("t1_out_rel", 64'(outs[i].rel), 64'(3 + i));

      // Rows 1 and 2 pivoted
      mark(8'd1); mark(8'd2);
      run_cmd(4, 0, 0, -1, -1);
      verify("t2", '{0, 3});

      // All four rows pivoted: empty command
      mark(8'd0); mark(8'd3); mark(8'd1);
      run_cmd(4, 0, 0, -1, -1);
      chk("t3_count",    64'(outs.size()), 64'd0);
      chk("t3_reads",    64'(rd_n),        64'd0);
      chk("t3_piv",      64'(piv_cnt),     64'd0);
      chk("t3_done_rel", 64'(done_rel),    64'd2);
      chk("t3_empty",    64'(done_empty),  64'd1);

      // Clear in the same cycle as start: start sees an empty bitmap
      run_cmd(4, 0, 1, -1, -1);
      verify("t3b", '{0, 1, 2, 3});

      // Back-pressure 1,0,0,1
      run_cmd(8, 1, 0, -1, -1);
      verify("t4", '{0, 1, 2, 3, 4, 5, 6, 7});

      // Duplicate mark and out-of-range mark count once; busy pokes ignored
      mark(8'd5); mark(8'd5); mark(8'd200);
      run_cmd(8, 0, 0, 3, -1);
      verify("t5", '{0, 1, 2, 3, 4, 6, 7});
      repeat (4) @(negedge clk);
      #2;
      chk("t5_idle_busy", 64'(busy),    64'd0);
      chk("t5_piv_total", 64'(piv_cnt), 64'd1);
      chk("t5_mark_rdy",  64'(mark_ready), 64'd1);

      // Reset mid-scan of N=16: no done, bitmap cleared (row 5 returns)
      run_cmd(16, 0, 0, -1, 6);
      repeat (5) @(negedge clk);
      chk("t6_no_done", 64'(done_n), 64'd0);
      run_cmd(6, 0, 0, -1, -1);
      verify("t6", '{0, 1, 2, 3, 4, 5});

      mon_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
